hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline, sitting beside the ID stage. It keeps its own shadow of in-flight writers (rd, write enable, load, MDU flags) for a configurable number of downstream stages, and produces per-read-port forwarding selects. It also generates the ID stall for load-use, multi-cycle MDU and branch-operand hazards, replacing purely combinational forwarding that compares pipeline-register fields.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register address width.
- NUM_FWD_STAGES, 3, tracked stages after ID (stage 0 = EX, 1 = MEM, 2 = WB); minimum 2.
- NUM_READ_PORTS, 2, source operands checked per instruction.
- MDU_LATENCY, 4, cycles an MDU instruction occupies EX; minimum 2.
- SEL_W (local), $clog2(NUM_FWD_STAGES+1), width of one forwarding select.

Ports:
- clk  in  1  clock; one clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  NUM_READ_PORTS*REG_ADDR_WIDTH  source addresses; port p in slice p.
- id_rs_used  in  NUM_READ_PORTS  port p is actually read.
- id_rd  in  REG_ADDR_WIDTH  destination.
- id_reg_wr_en  in  1  instruction writes rd.
- id_is_load  in  1  result available only at end of stage 1.
- id_is_mdu  in  1  multi-cycle multiply/divide.
- id_is_branch  in  1  ID-resolved branch/jalr.
- flush  in  1  squash the ID instruction (taken branch).
- fwd_sel  out  NUM_READ_PORTS*SEL_W  per port: 0 = register file, k = result of stage k-1.
- stall  out  1  hold PC and IF/ID.
- mdu_busy  out  1  MDU instruction counting in EX.

## Operation
- Entry per stage: valid, rd, wr, load, mdu. Entry "writes r" when valid & wr & rd == r & r != 0.
- Forward select per used port: lowest k-1 whose entry writes rs → k; none, or port unused, or rs == 0 → 0. Unused ports yield 0 and never cause stall.
- Load-use: port matches stage 0 entry with load=1 → stall.
- MDU hold: stage 0 entry mdu=1 and counter != 0 → stall, mdu_busy=1.
- Advance when no MDU hold: stage k+1 ← stage k; stage 0 ← ID fields if id_valid & ~stall & ~flush, else bubble (valid=0).
- Advance during MDU hold: stage 0 retained; stage 1 ← bubble; stages ≥2 shift normally.
- MDU counter: loaded with MDU_LATENCY-1 when an MDU instruction enters stage 0; decrements each cycle while nonzero; hold ends when counter reaches 0, at which point the instruction advances on the next edge.
- Flush with stall: flush wins capture (bubble); older stages unaffected; MDU counting continues.
- stall=0 whenever id_valid=0.

## Timing
- fwd_sel, stall, mdu_busy combinational from ID inputs and registered state; zero-cycle latency.
- Entries and counter update on clk rising edge; instruction issued in cycle n is visible as stage 0 in cycle n+1.
- Load followed by dependent instruction: exactly one stall cycle, then fwd_sel = 2.
- MDU in EX: mdu_busy high for MDU_LATENCY-1 cycles after entry.
- Reset (asynchronous, any time including mid-MDU): all entries invalid, counter 0; outputs fwd_sel=0, stall=0, mdu_busy=0 immediately.

## Configuration
- HAZ_BRANCH_ID_EN defined: for id_is_branch, a used port that matches a stage 0 entry (any) or a stage 1 entry with load=1 → stall. Branch operands are then forwarded only from stage ≥1 (non-load) via fwd_sel.
- Undefined: id_is_branch ignored; branches follow normal EX-stage rules.

## Structure
- Shared package header: SEL_W function, select encodings (SEL_RF = 0), and stage entry field widths/offsets.
- One sub-module, hazard_match: one read port against all entries → fwd_sel slice plus load/branch hit flags; instantiated NUM_READ_PORTS times via generate.

## Test plan
- add x5 issued, then sub reading x5 on port 0 next cycle → fwd_sel[0]=1, stall=0; one cycle later, with a bubble between → fwd_sel[0]=2.
- lw x7, then add x8,x7,x7 → one stall cycle; on release fwd_sel = {2,2}; writer to x0 never forwards (fwd_sel=0).
- mul x9 with MDU_LATENCY=4 → mdu_busy high 3 cycles, stall high 3 cycles, stage 1 bubbles; dependent add then gets fwd_sel=1.
- Two writers to x3 in stages 0 and 1 → select 1 (youngest wins).
- HAZ_BRANCH_ID_EN: addi x4, then beq x4 → one stall, then fwd_sel=2; lw x4, then beq x4 → two stalls.
- rst_n low during an MDU count, then released → all outputs 0, next issue is tracked normally; flush together with stall → no entry captured.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared select encoding, stage-entry field layout and width helpers
package hazard_scoreboard_pkg;

  localparam int SEL_RF = 0;

  // Entry layout: {rd, mdu, load, wr, valid}, valid in bit 0
  localparam int ENT_VALID  = 0;
  localparam int ENT_WR     = 1;
  localparam int ENT_LOAD   = 2;
  localparam int ENT_MDU    = 3;
  localparam int ENT_RD_LSB = 4;

  function automatic int sel_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

  function automatic int ent_width(input int reg_addr_width);
    return ENT_RD_LSB + reg_addr_width;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage hazard query bus between decode (master) and scoreboard (slave)
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_FWD_STAGES = 3,
  parameter int NUM_READ_PORTS = 2
);
  import hazard_scoreboard_pkg::*;

  localparam int SEL_W = sel_width(NUM_FWD_STAGES);

  logic                                     id_valid;
  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] id_rs;
  logic [NUM_READ_PORTS-1:0]                id_rs_used;
  logic [REG_ADDR_WIDTH-1:0]                id_rd;
  logic                                     id_reg_wr_en;
  logic                                     id_is_load;
  logic                                     id_is_mdu;
  logic                                     id_is_branch;
  logic                                     flush;
  logic [NUM_READ_PORTS*SEL_W-1:0]          fwd_sel;
  logic                                     stall;
  logic                                     mdu_busy;

  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_reg_wr_en,
           id_is_load, id_is_mdu, id_is_branch, flush,
    input  fwd_sel, stall, mdu_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rd, id_reg_wr_en,
           id_is_load, id_is_mdu, id_is_branch, flush,
    output fwd_sel, stall, mdu_busy
  );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// rtl/hazard_scoreboard_match.sv - hazard_match: one read port against every tracked stage entry
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_FWD_STAGES = 3,
  localparam int SEL_W = sel_width(NUM_FWD_STAGES),
  localparam int ENT_W = ent_width(REG_ADDR_WIDTH)
) (
  input  logic [NUM_FWD_STAGES*ENT_W-1:0] entries,
  input  logic [REG_ADDR_WIDTH-1:0]       rs,
  input  logic                            rs_used,
  output logic [SEL_W-1:0]                sel,
  output logic                            load_hit,
  output logic                            branch_hit
);

  logic [NUM_FWD_STAGES-1:0] hit;
  logic                      unused_fields;

  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_FWD_STAGES; k++) begin
      hit[k] = rs_used && (rs != '0)
               && entries[k*ENT_W + ENT_VALID]
               && entries[k*ENT_W + ENT_WR]
               && (entries[k*ENT_W + ENT_RD_LSB +: REG_ADDR_WIDTH] == rs);
    end
  end

  // Scan oldest to youngest so the youngest writer overrides
  always_comb begin
    sel = SEL_W'(SEL_RF);
    for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
      if (hit[k]) sel = SEL_W'(k + 1);
    end
  end

  assign load_hit   = hit[0] & entries[ENT_LOAD];
  assign branch_hit = hit[0] | (hit[1] & entries[ENT_W + ENT_LOAD]);

  // MDU flags and late-stage load flags do not affect a single port's match
  assign unused_fields = ^entries;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight writer shadow, forwarding selects, load-use/MDU stall
// Optional HAZ_BRANCH_ID_EN: stall ID-resolved branches until operands are forwardable from stage >= 1
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_FWD_STAGES = 3,
  parameter int NUM_READ_PORTS = 2,
  parameter int MDU_LATENCY    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  bus
);

  localparam int SEL_W = sel_width(NUM_FWD_STAGES);
  localparam int ENT_W = ent_width(REG_ADDR_WIDTH);
  localparam int CNT_W = $clog2(MDU_LATENCY);

  logic [NUM_FWD_STAGES-1:0][ENT_W-1:0] ent;
  logic [CNT_W-1:0]                     mdu_cnt;
  logic [NUM_READ_PORTS-1:0]            load_hit;
  logic [NUM_READ_PORTS-1:0]            branch_hit;
  logic [ENT_W-1:0]                     id_entry;
  logic                                 mdu_hold;
  logic                                 hazard;
  logic                                 capture;

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    hazard_match #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
      .NUM_FWD_STAGES (NUM_FWD_STAGES)
    ) u_match (
      .entries    (ent),
      .rs         (bus.id_rs[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
      .rs_used    (bus.id_rs_used[p]),
      .sel        (bus.fwd_sel[p*SEL_W +: SEL_W]),
      .load_hit   (load_hit[p]),
      .branch_hit (branch_hit[p])
    );
  end

  assign mdu_hold = ent[0][ENT_VALID] & ent[0][ENT_MDU] & (mdu_cnt != '0);

`ifdef HAZ_BRANCH_ID_EN
  assign hazard = (|load_hit) | mdu_hold | (bus.id_is_branch & (|branch_hit));
`else
  logic unused_branch;
  assign unused_branch = bus.id_is_branch ^ (^branch_hit);
  assign hazard        = (|load_hit) | mdu_hold;
`endif

  assign bus.stall    = bus.id_valid & hazard;
  assign bus.mdu_busy = mdu_hold;
  assign capture      = bus.id_valid & ~bus.stall & ~bus.flush;

  always_comb begin
    id_entry = '0;
    if (capture) begin
      id_entry[ENT_VALID]                        = 1'b1;
      id_entry[ENT_WR]                           = bus.id_reg_wr_en;
      id_entry[ENT_LOAD]                         = bus.id_is_load;
      id_entry[ENT_MDU]                          = bus.id_is_mdu;
      id_entry[ENT_RD_LSB +: REG_ADDR_WIDTH]     = bus.id_rd;
    end
  end

  // While the MDU op holds EX, MEM sees bubbles and older stages keep draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent     <= '0;
      mdu_cnt <= '0;
    end else begin
      for (int k = NUM_FWD_STAGES - 1; k >= 2; k--) begin
        ent[k] <= ent[k-1];
      end
      if (mdu_hold) begin
        ent[1] <= '0;
      end else begin
        ent[1] <= ent[0];
        ent[0] <= id_entry;
      end
      if (capture && bus.id_is_mdu) begin
        mdu_cnt <= CNT_W'(MDU_LATENCY - 1);
      end else if (mdu_cnt != '0) begin
        mdu_cnt <= mdu_cnt - 1'b1;
      end
    end
  end

endmodule
